// File: rtl/sys_types_pkg.sv
// Shared types for the pooling datapath: int8 sample type, write-back FIFO entry, FSM states.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package sys_types;

    typedef logic signed [7:0] int8_t;

    localparam int WORD_BYTES     = 4;
    // Widest pooled matrix the write-back entry is sized for; lin = row*w + col fits in 2*log2 bits.
    localparam int POOL_WB_MAX_N  = 64;
    localparam int POOL_WB_LIN_W  = 2 * $clog2(POOL_WB_MAX_N);

    typedef struct packed {
        logic [POOL_WB_LIN_W-1:0] lin;
        int8_t                    data;
    } pool_wb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } pool_wb_state_e;

    // Place a byte into its lane of a memory word, other lanes zero.
    function automatic logic [8*WORD_BYTES-1:0] lane_place(input int8_t b, input logic [1:0] lane);
        lane_place = {{(8*WORD_BYTES-8){1'b0}}, b} << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/pool_wb_fifo.sv
// Synchronous FIFO with full/empty flags; pop_data shows the head entry combinationally.
// Latency: a pushed entry is visible at pop_data the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens the same cycle (slot reused).
// Ports: clk, reset (async, active-high), push/push_data, pop/pop_data, full, empty.
module pool_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    // DEPTH must be a power of two so the pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pool_writeback.sv
// Pooled int8 results -> byte-merged 32-bit memory writes with byte enables; tracks layer end.
// Latency: sample poppable 1 cycle after arrival; a word-completing byte reaches mem_we 2 cycles later.
// Backpressure: mem_ready stalls hold the write and stop pops; input FIFO absorbs, overflow drops (sticky flag).
// Ports: clk, reset (async, active-high); start/out_w/out_h/base_addr layer config;
//        in_valid/in_row/in_col/in_data sample stream; mem_we/mem_addr/mem_wdata/mem_be/mem_ready write port;
//        busy, done (1-cycle pulse), overflow (sticky).
// Build option: define POOL_WB_RELU_EN to clamp negative samples to zero on entry.
module pool_writeback
    import sys_types::*;
#(
    parameter int MAX_N      = 64,
    parameter int N_BITS     = $clog2(MAX_N),
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] out_w,
    input  logic [N_BITS-1:0] out_h,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [N_BITS-1:0] in_row,
    input  logic [N_BITS-1:0] in_col,
    input  int8_t             in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int LIN_W = 2 * N_BITS;
    localparam int CNT_W = LIN_W + 1;

    pool_wb_state_e state, state_n;

    logic [N_BITS-1:0] cfg_w, cfg_h;
    logic [ADDR_W-1:0] cfg_base;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  total;
    logic              overflow_r;

    // Merge register: word being assembled.
    logic              m_vld, m_vld_n;
    logic [ADDR_W-1:0] m_addr, m_addr_n;
    logic [31:0]       m_data, m_data_n;
    logic [3:0]        m_be, m_be_n;

    // Write register: drives the memory port, held until accepted.
    logic              wr_vld, wr_vld_n;
    logic [ADDR_W-1:0] wr_addr, wr_addr_n;
    logic [31:0]       wr_data, wr_data_n;
    logic [3:0]        wr_be, wr_be_n;

    logic              push_ok, drop, wr_free;
    logic [LIN_W-1:0]  lin;
    int8_t             push_val;
    pool_wb_entry_t    entry_in, entry_out;
    logic              fifo_pop, fifo_full, fifo_empty;

    logic [LIN_W-1:0]  p_lin;
    logic [ADDR_W-1:0] p_addr;
    logic [1:0]        p_lane;
    logic              hit;
    logic [3:0]        merged_be;
    logic [31:0]       merged_data;

`ifdef POOL_WB_RELU_EN
    assign push_val = in_data[7] ? int8_t'(0) : in_data;
`else
    assign push_val = in_data;
`endif

    assign lin     = LIN_W'(in_row) * LIN_W'(cfg_w) + LIN_W'(in_col);
    assign total   = CNT_W'(cfg_h) * CNT_W'(cfg_w);
    assign push_ok = in_valid && (state == S_RUN);
    // A write accepted this cycle frees the write register for a new one.
    assign wr_free  = !wr_vld || mem_ready;
    assign fifo_pop = !fifo_empty && wr_free;
    assign drop     = push_ok && fifo_full && !fifo_pop;

    assign entry_in.lin  = POOL_WB_LIN_W'(lin);
    assign entry_in.data = push_val;

    pool_wb_fifo #(
        .WIDTH ($bits(pool_wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (entry_in),
        .pop       (fifo_pop),
        .pop_data  (entry_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign p_lin       = LIN_W'(entry_out.lin);
    assign p_lane      = p_lin[1:0];
    assign p_addr      = cfg_base + ADDR_W'(p_lin[LIN_W-1:2]);
    assign hit         = m_vld && (m_addr == p_addr) && !m_be[p_lane];
    assign merged_be   = m_be | (4'b0001 << p_lane);
    assign merged_data = m_data | lane_place(entry_out.data, p_lane);

    always_comb begin
        m_vld_n   = m_vld;
        m_addr_n  = m_addr;
        m_data_n  = m_data;
        m_be_n    = m_be;
        wr_vld_n  = wr_vld && !mem_ready;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        wr_be_n   = wr_be;
        if (fifo_pop) begin
            if (hit) begin
                if (&merged_be) begin
                    // Completed word goes straight out instead of waiting for a differing address.
                    wr_vld_n  = 1'b1;
                    wr_addr_n = m_addr;
                    wr_data_n = merged_data;
                    wr_be_n   = merged_be;
                    m_vld_n   = 1'b0;
                    m_data_n  = '0;
                    m_be_n    = '0;
                end else begin
                    m_data_n = merged_data;
                    m_be_n   = merged_be;
                end
            end else begin
                // Different word or duplicate lane: retire the old word, start a new one.
                if (m_vld) begin
                    wr_vld_n  = 1'b1;
                    wr_addr_n = m_addr;
                    wr_data_n = m_data;
                    wr_be_n   = m_be;
                end
                m_vld_n  = 1'b1;
                m_addr_n = p_addr;
                m_data_n = lane_place(entry_out.data, p_lane);
                m_be_n   = 4'b0001 << p_lane;
            end
        end else if ((state == S_FLUSH) && m_vld && wr_free) begin
            wr_vld_n  = 1'b1;
            wr_addr_n = m_addr;
            wr_data_n = m_data;
            wr_be_n   = m_be;
            m_vld_n   = 1'b0;
            m_data_n  = '0;
            m_be_n    = '0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if ((count == total) && fifo_empty) state_n = S_FLUSH;
            S_FLUSH: if (!m_vld && wr_free) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cfg_w      <= '0;
            cfg_h      <= '0;
            cfg_base   <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
            m_vld      <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
            m_be       <= '0;
            wr_vld     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_be      <= '0;
        end else begin
            state   <= state_n;
            m_vld   <= m_vld_n;
            m_addr  <= m_addr_n;
            m_data  <= m_data_n;
            m_be    <= m_be_n;
            wr_vld  <= wr_vld_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            wr_be   <= wr_be_n;
            if ((state == S_IDLE) && start) begin
                cfg_w      <= out_w;
                cfg_h      <= out_h;
                cfg_base   <= base_addr;
                count      <= '0;
                overflow_r <= 1'b0;
            end else begin
                // Dropped samples still count so the layer always terminates.
                if (push_ok) count <= count + CNT_W'(1);
                if (drop)    overflow_r <= 1'b1;
            end
        end
    end

    assign mem_we    = wr_vld;
    assign mem_addr  = wr_addr;
    assign mem_wdata = wr_data;
    assign mem_be    = wr_be;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_pool_writeback.sv
// Self-checking bench for pool_writeback: table of raster layers plus hand sequences
// (out-of-order merge, duplicate lane, stall/overflow, reset mid-layer, RELU option).
// Expected writes are queued when stimulus is driven and popped as the DUT's writes are accepted.
module tb_pool_writeback;
    import sys_types::*;

    localparam int N_BITS = 6;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N_BITS-1:0] out_w, out_h;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic [N_BITS-1:0] in_row, in_col;
    int8_t             in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic              busy, done, overflow;

    pool_writeback dut (
        .clk(clk), .reset(reset), .start(start), .out_w(out_w), .out_h(out_h),
        .base_addr(base_addr), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
        .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } wr_t;
    wr_t sb[$];

    int          n_writes = 0;
    logic [3:0]  last_be = '0;
    bit          hold_vld = 0;
    wr_t         held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
        wr_t w;
        w.addr = a; w.wdata = d; w.be = b;
        return w;
    endfunction

    // Write monitor: scoreboard pops, hold stability, unused lanes zero.
    always @(negedge clk) begin
        if (reset) begin
            hold_vld = 0;
        end else begin
            if (hold_vld) begin
                chk("hold_we",    {31'b0, mem_we}, 32'd1);
                chk("hold_addr",  {20'b0, mem_addr}, {20'b0, held.addr});
                chk("hold_wdata", mem_wdata, held.wdata);
                chk("hold_be",    {28'b0, mem_be}, {28'b0, held.be});
            end
            hold_vld = 0;
            if (mem_we) begin
                chk("unused_lanes_zero",
                    mem_wdata & ~{{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}}, 32'd0);
                if (mem_ready) begin
                    n_writes++;
                    last_be = mem_be;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h be %b, expected none",
                                 mem_addr, mem_wdata, mem_be);
                    end else begin
                        wr_t e;
                        e = sb.pop_front();
                        chk("wr_addr",  {20'b0, mem_addr}, {20'b0, e.addr});
                        chk("wr_wdata", mem_wdata, e.wdata);
                        chk("wr_be",    {28'b0, mem_be}, {28'b0, e.be});
                    end
                end else begin
                    hold_vld   = 1;
                    held.addr  = mem_addr;
                    held.wdata = mem_wdata;
                    held.be    = mem_be;
                end
            end
        end
    end

    task automatic do_start(input int w, input int h, input logic [ADDR_W-1:0] b);
        start = 1'b1;
        out_w = N_BITS'(w);
        out_h = N_BITS'(h);
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("overflow_cleared", {31'b0, overflow}, 32'd0);
    endtask

    task automatic send(input int r, input int c, input logic [7:0] d);
        in_valid = 1'b1;
        in_row   = N_BITS'(r);
        in_col   = N_BITS'(c);
        in_data  = int8_t'(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: no done pulse within %0d cycles, expected one", name, n);
        end
        @(negedge clk);
        chk({name, "_done_width"}, {31'b0, done}, 32'd0);
        chk({name, "_idle"}, {31'b0, busy}, 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int                w;
        int                h;
        logic [ADDR_W-1:0] base;
        int                exp_writes;
        logic [3:0]        exp_last_be;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   nw0;
        vt[0] = '{w: 4, h: 1, base: 12'h010, exp_writes: 1, exp_last_be: 4'b1111};
        vt[1] = '{w: 3, h: 1, base: 12'h020, exp_writes: 1, exp_last_be: 4'b0111};
        vt[2] = '{w: 5, h: 3, base: 12'h100, exp_writes: 4, exp_last_be: 4'b0111};
        vt[3] = '{w: 4, h: 2, base: 12'hFFF, exp_writes: 2, exp_last_be: 4'b1111};
        vt[4] = '{w: 1, h: 1, base: 12'h000, exp_writes: 1, exp_last_be: 4'b0001};

        reset = 1'b1; start = 1'b0; out_w = '0; out_h = '0; base_addr = '0;
        in_valid = 1'b0; in_row = '0; in_col = '0; in_data = '0; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        chk("rst_busy",      {31'b0, busy}, 32'd0);
        chk("rst_done",      {31'b0, done}, 32'd0);
        chk("rst_overflow",  {31'b0, overflow}, 32'd0);
        chk("rst_mem_be",    {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Raster-order layers; expected words derived from the linear index range.
        for (int i = 0; i < 5; i++) begin
            int total;
            total = vt[i].w * vt[i].h;
            nw0 = n_writes;
            do_start(vt[i].w, vt[i].h, vt[i].base);
            for (int k = 0; 4 * k < total; k++) begin
                logic [3:0]  be;
                logic [31:0] wd;
                be = '0;
                wd = '0;
                for (int l = 0; l < 4; l++) begin
                    if (4 * k + l < total) begin
                        be[l] = 1'b1;
                        wd[8*l +: 8] = 8'(4 * k + l + 1);
                    end
                end
                sb.push_back(mk(vt[i].base + ADDR_W'(k), wd, be));
            end
            for (int r = 0; r < vt[i].h; r++)
                for (int c = 0; c < vt[i].w; c++)
                    send(r, c, 8'(r * vt[i].w + c + 1));
            if (i == 0) begin
                @(negedge clk);
                chk("latency_t1_no_write", {31'b0, mem_we}, 32'd0);
                @(negedge clk);
                chk("latency_t2_write", {31'b0, mem_we}, 32'd1);
                @(posedge clk); #1;
            end
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_nwrites", i), 32'(n_writes - nw0), 32'(vt[i].exp_writes));
            chk($sformatf("vec%0d_last_be", i), {28'b0, last_be}, {28'b0, vt[i].exp_last_be});
        end

        // Out-of-order arrival over two words.
        nw0 = n_writes;
        do_start(4, 2, 12'h040);
        sb.push_back(mk(12'h041, 32'h0000A500, 4'b0010));
        sb.push_back(mk(12'h040, 32'h000000A0, 4'b0001));
        sb.push_back(mk(12'h041, 32'h000000A4, 4'b0001));
        sb.push_back(mk(12'h040, 32'hA3A2A100, 4'b1110));
        sb.push_back(mk(12'h041, 32'hA7A60000, 4'b1100));
        send(1, 1, 8'hA5); send(0, 0, 8'hA0); send(1, 0, 8'hA4); send(0, 1, 8'hA1);
        send(0, 2, 8'hA2); send(0, 3, 8'hA3); send(1, 2, 8'hA6); send(1, 3, 8'hA7);
        wait_done("ooo");
        chk("ooo_nwrites", 32'(n_writes - nw0), 32'd5);

        // Same lane twice: old word written first, then the new one.
        do_start(2, 1, 12'h300);
        sb.push_back(mk(12'h300, 32'h00000011, 4'b0001));
        sb.push_back(mk(12'h300, 32'h00000022, 4'b0001));
        send(0, 0, 8'h11);
        send(0, 0, 8'h22);
        wait_done("dup");

        // Memory stall: 8 samples on distinct words, last two dropped.
        nw0 = n_writes;
        mem_ready = 1'b0;
        do_start(8, 1, 12'h200);
        for (int r = 0; r < 6; r++)
            sb.push_back(mk(12'h200 + ADDR_W'(2 * r), 32'(8'h10 + r), 4'b0001));
        for (int r = 0; r < 8; r++)
            send(r, 0, 8'(8'h10 + r));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_overflow_seen", {31'b0, overflow}, 32'd1);
        mem_ready = 1'b1;
        wait_done("stall");
        chk("stall_nwrites", 32'(n_writes - nw0), 32'd6);
        chk("stall_overflow_sticky", {31'b0, overflow}, 32'd1);

        // Reset with a write pending, then a normal layer.
        mem_ready = 1'b0;
        do_start(8, 1, 12'h400);
        send(0, 0, 8'h55); send(1, 0, 8'h66); send(2, 0, 8'h77);
        begin
            int n;
            n = 0;
            while (mem_we !== 1'b1 && n < 10) begin @(negedge clk); n++; end
            chk("rstmid_write_pending", {31'b0, mem_we}, 32'd1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        do_start(4, 1, 12'h020);
        sb.push_back(mk(12'h020, 32'h44332211, 4'b1111));
        send(0, 0, 8'h11); send(0, 1, 8'h22); send(0, 2, 8'h33); send(0, 3, 8'h44);
        wait_done("after_rst");

        // Negative sample: clamped only when the RELU option is built in.
        do_start(1, 1, 12'h310);
`ifdef POOL_WB_RELU_EN
        sb.push_back(mk(12'h310, 32'h00000000, 4'b0001));
`else
        sb.push_back(mk(12'h310, 32'h000000FB, 4'b0001));
`endif
        send(0, 0, 8'hFB);
        wait_done("relu");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pool_writeback.md
Name: pool_writeback

Overview:
- Downstream of the maxpool stage: accepts one pooled int8 result per cycle (valid/row/col/data, no backpressure upstream).
- Converts (row,col) to a linear activation-memory address and merges bytes into 32-bit words with byte enables.
- Issues writes over a valid/ready memory port; an elastic FIFO absorbs memory stalls.
- Tracks layer completion and flushes the trailing partial word.

Parameters:
- MAX_N, 64, max pooled matrix dimension.
- N_BITS, $clog2(MAX_N), width of row/col/dimension fields.
- ADDR_W, 12, memory word-address width.
- FIFO_DEPTH, 4, entries in input FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; latches out_w/out_h/base_addr and begins a layer.
- out_w  in  N_BITS  pooled output width; 0 is illegal.
- out_h  in  N_BITS  pooled output height; 0 is illegal.
- base_addr  in  ADDR_W  word address of pooled element (0,0).
- in_valid  in  1  pooled sample valid.
- in_row  in  N_BITS  absolute pooled row.
- in_col  in  N_BITS  absolute pooled col.
- in_data  in  8  signed pooled value (int8_t).
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  byte lane k = bits [8k+7:8k].
- mem_be  out  4  byte enables.
- mem_ready  in  1  write accepted when mem_we && mem_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at layer end.
- overflow  out  1  sticky; a sample was dropped.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO empty; merge register invalid; sample count 0.
- FSM states:
  - IDLE: start -> RUN. Latch config, clear count and overflow.
  - RUN: when count == out_h*out_w and FIFO empty -> FLUSH.
  - FLUSH: if merge register valid, hold the write until accepted, then -> DONE. If invalid, -> DONE immediately.
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Push: in_valid in RUN pushes {lin, data}, where lin = in_row*out_w + in_col (2*N_BITS bits, unsigned); count increments.
  - In IDLE/FLUSH/DONE, in_valid is ignored and not counted.
  - Push while FIFO full: sample dropped, overflow <= 1, count still increments so the layer terminates.
- Address: word = base_addr + lin[2*N_BITS-1:2], truncated to ADDR_W (wraps silently); lane = lin[1:0].
- Pop: at most one per cycle, only when no write is pending un-accepted.
  - If merge valid, same word, and lane's be bit clear: OR byte into lane, set be bit.
  - Otherwise: emit the merge register as a write (mem_we=1) and load the popped entry as the new merge word.
  - If merge invalid: load directly.
- Full-word flush: when be reaches 4'b1111 the word is emitted the next cycle without waiting for a differing address.
- Write hold: mem_we/addr/wdata/be stay stable until mem_ready; no pops while a write is pending. Unused lanes in wdata are 0.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the push succeeds.
- Latency: sample at cycle t is earliest poppable at t+1. A completing byte yields mem_we at t+2 at the earliest.
- Duplicate lane on the same word: treated as a new word; the old word is written first and not overwritten in place.
- Reset mid-layer: everything is abandoned; no write is issued.

Optional Feature:
- POOL_WB_RELU_EN defined: negative in_data is clamped to 0 at push; all other behaviour unchanged.
- Undefined: data is passed unmodified.

Decomposition:
- sys_types package: int8_t (existing); add typedef pool_wb_entry_t {lin, data}; localparam WORD_BYTES=4; FSM enum pool_wb_state_e.
- One sub-module, pool_wb_fifo: synchronous FIFO with full/empty, parameterised width and depth.
- Merge/FSM logic lives in the top.

Test Plan:
- Contiguous row: out_w=4, out_h=1, base=0x10. Samples (0,0..3)=1,2,3,4 on consecutive cycles, mem_ready=1 -> single write addr 0x10, wdata 0x04030201, be 4'b1111, then done pulse.
- Partial tail: out_w=3, out_h=1. Three samples -> one write, be 4'b0111, emitted in FLUSH; done follows acceptance.
- Out-of-order merge: out_w=4, out_h=2. Order (1,1),(0,0),(1,0),(0,1)... -> writes by word address; all 8 bytes correct; no byte lost.
- Stall/overflow: FIFO_DEPTH=4, mem_ready=0 for 10 cycles, 8 samples at distinct word addresses -> overflow=1, exactly the dropped samples absent, done still asserted.
- Reset mid-layer: assert reset with a write pending -> mem_we=0 immediately, busy=0; a new start works normally.
- RELU (macro on): in_data=-5 -> byte 0x00 written; macro off -> 0xFB.
